average_run_ctrl: RTL

Run controller for the average accelerator core. Sits between the host memory-mapped bus and the HLS core's start/done sync handshakes, next to the configuration register slave. Snapshots the configuration words (count, index_hi, index_lo) at launch, sequences one run per host start command, measures run cycles, enforces an optional timeout, and exposes control/status registers.

---
 rtl/average_pkg.sv | 24 ++
 rtl/average_run_fsm.sv | 103 ++++++++++
 rtl/average_run_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/average_pkg.sv
// Shared constants and types for the average accelerator run controller.
package average_pkg;

  localparam int unsigned CTRL_ADDR    = 32'h0;
  localparam int unsigned STATUS_ADDR  = 32'h4;
  localparam int unsigned CYCLES_ADDR  = 32'h8;
  localparam int unsigned TIMEOUT_ADDR = 32'hC;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_ABORT_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  localparam int unsigned ST_BUSY_BIT    = 0;
  localparam int unsigned ST_DONE_BIT    = 1;
  localparam int unsigned ST_TIMEOUT_BIT = 2;
  localparam int unsigned ST_ABORTED_BIT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } run_state_t;

endpackage

// File: rtl/average_run_fsm.sv
// Run sequencer: start/done handshakes with the core, cycle counter,
// timeout compare and the sticky completion flags.
module average_run_fsm
  import average_pkg::*;
#(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_clr_done,
  input  logic             i_clr_timeout,
  input  logic             i_clr_aborted,
  input  logic [CYC_W-1:0] i_timeout_limit,
  input  logic             i_core_start_rdy,
  input  logic             i_core_done_vld,
  output run_state_t       o_state,
  output logic             o_busy,
  output logic             o_core_start_vld,
  output logic             o_core_done_rdy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_aborted,
  output logic [CYC_W-1:0] o_cycles
);

  run_state_t       r_state;
  logic             r_busy;
  logic             r_start_vld;
  logic             r_done_rdy;
  logic             r_done;
  logic             r_timeout;
  logic             r_aborted;
  logic [CYC_W-1:0] r_cycles;

  logic w_done_hs;
  logic w_timeout_hit;

  assign w_done_hs     = (r_state == RUN) && r_done_rdy && i_core_done_vld;
  assign w_timeout_hit = (i_timeout_limit != '0) && (r_cycles == i_timeout_limit);

  // Sticky clears are applied first so a same-cycle set from the FSM wins.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_start_vld <= 1'b0;
      r_done_rdy  <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_aborted   <= 1'b0;
      r_cycles    <= '0;
    end else begin
      if (i_clr_done)    r_done    <= 1'b0;
      if (i_clr_timeout) r_timeout <= 1'b0;
      if (i_clr_aborted) r_aborted <= 1'b0;

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= LAUNCH;
            r_busy      <= 1'b1;
            r_start_vld <= 1'b1;
            r_cycles    <= '0;
          end
        end
        LAUNCH, RUN: begin
          if (r_cycles != '1) r_cycles <= r_cycles + CYC_W'(1);
          if (w_done_hs || w_timeout_hit || i_abort) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_start_vld <= 1'b0;
            r_done_rdy  <= 1'b0;
            if (w_done_hs)          r_done    <= 1'b1;
            else if (w_timeout_hit) r_timeout <= 1'b1;
            else                    r_aborted <= 1'b1;
          end else if ((r_state == LAUNCH) && i_core_start_rdy) begin
            r_state     <= RUN;
            r_start_vld <= 1'b0;
            r_done_rdy  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_start_vld <= 1'b0;
          r_done_rdy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state          = r_state;
  assign o_busy           = r_busy;
  assign o_core_start_vld = r_start_vld;
  assign o_core_done_rdy  = r_done_rdy;
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;
  assign o_aborted        = r_aborted;
  assign o_cycles         = r_cycles;

endmodule

// File: rtl/average_run_ctrl.sv
// Average accelerator run controller: register decode, read mux and config
// snapshots. Define AVERAGE_RUN_CTRL_IRQ_EN to add the irq output and IRQ_EN bit.
module average_run_ctrl
  import average_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CYC_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  output logic              waddr_error,
  output logic              raddr_error,
  input  logic [DATA_W-1:0] cfg_count,
  input  logic [DATA_W-1:0] cfg_index_hi,
  input  logic [DATA_W-1:0] cfg_index_lo,
  output logic [DATA_W-1:0] count_rsc_dat,
  output logic [DATA_W-1:0] index_hi_rsc_dat,
  output logic [DATA_W-1:0] index_lo_rsc_dat,
  output logic              core_start_vld,
  input  logic              core_start_rdy,
  input  logic              core_done_vld,
  output logic              core_done_rdy,
  output logic              busy
`ifdef AVERAGE_RUN_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [DATA_W-1:0] r_rdata;
  logic              r_waddr_error;
  logic              r_raddr_error;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_index_hi;
  logic [DATA_W-1:0] r_index_lo;
  logic [CYC_W-1:0]  r_timeout_limit;

  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_wr_cycles;
  logic              w_wr_timeout;
  logic              w_start;
  logic              w_abort;
  logic              w_irq_en;
  run_state_t        w_state;
  logic              w_busy;
  logic              w_done;
  logic              w_timeout;
  logic              w_aborted;
  logic [CYC_W-1:0]  w_cycles;
  logic [DATA_W-1:0] w_ctrl_rd;
  logic [DATA_W-1:0] w_status_rd;

  assign w_wr_ctrl    = wen && (addr == ADDR_W'(CTRL_ADDR));
  assign w_wr_status  = wen && (addr == ADDR_W'(STATUS_ADDR));
  assign w_wr_cycles  = wen && (addr == ADDR_W'(CYCLES_ADDR));
  assign w_wr_timeout = wen && (addr == ADDR_W'(TIMEOUT_ADDR));
  assign w_start      = w_wr_ctrl && wdata[CTRL_START_BIT];
  assign w_abort      = w_wr_ctrl && wdata[CTRL_ABORT_BIT];

  average_run_fsm #(
    .CYC_W (CYC_W)
  ) u_fsm (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_start          (w_start),
    .i_abort          (w_abort),
    .i_clr_done       (w_wr_status && wdata[ST_DONE_BIT]),
    .i_clr_timeout    (w_wr_status && wdata[ST_TIMEOUT_BIT]),
    .i_clr_aborted    (w_wr_status && wdata[ST_ABORTED_BIT]),
    .i_timeout_limit  (r_timeout_limit),
    .i_core_start_rdy (core_start_rdy),
    .i_core_done_vld  (core_done_vld),
    .o_state          (w_state),
    .o_busy           (w_busy),
    .o_core_start_vld (core_start_vld),
    .o_core_done_rdy  (core_done_rdy),
    .o_done           (w_done),
    .o_timeout        (w_timeout),
    .o_aborted        (w_aborted),
    .o_cycles         (w_cycles)
  );

`ifdef AVERAGE_RUN_CTRL_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= wdata[CTRL_IRQ_EN_BIT];
      r_irq <= r_irq_en && (w_done || w_timeout || w_aborted);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  // Unmapped write detection and the writable timeout limit; CYCLES writes are dropped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_waddr_error   <= 1'b0;
      r_timeout_limit <= '0;
    end else begin
      r_waddr_error <= wen && !(w_wr_ctrl || w_wr_status || w_wr_cycles || w_wr_timeout);
      if (w_wr_timeout) r_timeout_limit <= CYC_W'(wdata);
    end
  end

  // Config snapshot taken only when a START is actually accepted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count    <= '0;
      r_index_hi <= '0;
      r_index_lo <= '0;
    end else if (w_start && (w_state == IDLE)) begin
      r_count    <= cfg_count;
      r_index_hi <= cfg_index_hi;
      r_index_lo <= cfg_index_lo;
    end
  end

  always_comb begin
    w_ctrl_rd                   = '0;
    w_ctrl_rd[CTRL_IRQ_EN_BIT]  = w_irq_en;
    w_status_rd                 = '0;
    w_status_rd[ST_BUSY_BIT]    = w_busy;
    w_status_rd[ST_DONE_BIT]    = w_done;
    w_status_rd[ST_TIMEOUT_BIT] = w_timeout;
    w_status_rd[ST_ABORTED_BIT] = w_aborted;
  end

  // Registered read mux; an unmapped read returns zero and flags the error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rdata       <= '0;
      r_raddr_error <= 1'b0;
    end else begin
      r_raddr_error <= 1'b0;
      if (ren) begin
        case (addr)
          ADDR_W'(CTRL_ADDR):    r_rdata <= w_ctrl_rd;
          ADDR_W'(STATUS_ADDR):  r_rdata <= w_status_rd;
          ADDR_W'(CYCLES_ADDR):  r_rdata <= DATA_W'(w_cycles);
          ADDR_W'(TIMEOUT_ADDR): r_rdata <= DATA_W'(r_timeout_limit);
          default: begin
            r_rdata       <= '0;
            r_raddr_error <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rdata            = r_rdata;
  assign waddr_error      = r_waddr_error;
  assign raddr_error      = r_raddr_error;
  assign count_rsc_dat    = r_count;
  assign index_hi_rsc_dat = r_index_hi;
  assign index_lo_rsc_dat = r_index_lo;
  assign busy             = w_busy;

endmodule
